i_prefetch_buffer: RTL and testbench

- Single-line next-line instruction prefetch buffer between the instruction cache's physical-memory port and physical memory (or the memory arbiter).
- Passes I-cache line misses through to memory and serves them from a 256-bit buffer when the line was already prefetched.
- After every demand line, fetches the following sequential line into the buffer.

---
 rtl/i_prefetch_buffer.sv | 144 ++++++++++++++
 tb/tb_i_prefetch_buffer.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i_prefetch_buffer.sv
// ============================================================================
// Module   : i_prefetch_buffer
// Purpose  : Single-line next-line instruction prefetch buffer sitting between
//            the I-cache memory port and physical memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i_prefetch_buffer #(
    parameter int PREFETCH_EN = 1,
    parameter int LINE_BITS   = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         icache_read,
    input  logic [31:0]  icache_address,
    output logic         icache_resp,
    output logic [255:0] icache_rdata,
    output logic         mem_read,
    output logic [31:0]  mem_address,
    input  logic         mem_resp,
    input  logic [255:0] mem_rdata,
    output logic [31:0]  pf_hit_count,
    output logic [31:0]  pf_issue_count
);

    localparam int c_TAG_W = 32 - LINE_BITS;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_HIT_RESP = 2'd1,
        S_DEMAND   = 2'd2,
        S_PREFETCH = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic                 r_buf_valid;
    logic [c_TAG_W-1:0]   r_buf_tag;
    logic [255:0]         r_buf_data;
    logic [c_TAG_W-1:0]   r_pf_tag;
    logic [c_TAG_W-1:0]   r_req_tag;
    logic [31:0]          r_hit_cnt;
    logic [31:0]          r_issue_cnt;
    logic [c_TAG_W-1:0]   w_req_tag;
    logic                 w_pf_en;
    logic                 w_buf_hit;
    logic                 w_enter_pf;
    logic                 w_unused_addr_bits;

    generate
        if (PREFETCH_EN != 0) begin : g_pf_on
            assign w_pf_en = 1'b1;
        end else begin : g_pf_off
            assign w_pf_en = 1'b0;
        end
    endgenerate

    assign w_req_tag          = icache_address[31:LINE_BITS];
    assign w_unused_addr_bits = ^icache_address[LINE_BITS-1:0];
    assign w_buf_hit          = r_buf_valid && (r_buf_tag == w_req_tag);
    assign w_enter_pf         = (w_next_state == S_PREFETCH) && (r_state != S_PREFETCH);
    assign pf_hit_count       = r_hit_cnt;
    assign pf_issue_count     = r_issue_cnt;

    always_comb begin
        w_next_state = r_state;
        icache_resp  = 1'b0;
        icache_rdata = '0;
        mem_read     = 1'b0;
        mem_address  = '0;
        case (r_state)
            S_IDLE: begin
                if (icache_read) begin
                    w_next_state = w_buf_hit ? S_HIT_RESP : S_DEMAND;
                end
            end
            S_HIT_RESP: begin
                icache_resp  = 1'b1;
                icache_rdata = r_buf_data;
                w_next_state = w_pf_en ? S_PREFETCH : S_IDLE;
            end
            S_DEMAND: begin
                mem_read    = 1'b1;
                mem_address = {r_req_tag, {LINE_BITS{1'b0}}};
                // Memory data is forwarded straight to the I-cache in the response cycle
                if (mem_resp) begin
                    icache_resp  = 1'b1;
                    icache_rdata = mem_rdata;
                    w_next_state = w_pf_en ? S_PREFETCH : S_IDLE;
                end
            end
            S_PREFETCH: begin
                mem_read    = 1'b1;
                mem_address = {r_pf_tag, {LINE_BITS{1'b0}}};
                if (mem_resp) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_buf_valid <= 1'b0;
            r_buf_tag   <= '0;
            r_buf_data  <= '0;
            r_pf_tag    <= '0;
            r_req_tag   <= '0;
            r_hit_cnt   <= '0;
            r_issue_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_IDLE && icache_read) begin
                r_req_tag <= w_req_tag;
            end
            // Tag arithmetic wraps naturally at the top of the address space
            if (w_enter_pf) begin
                r_pf_tag <= r_req_tag + c_TAG_W'(1);
                if (r_issue_cnt != 32'hFFFF_FFFF) begin
                    r_issue_cnt <= r_issue_cnt + 32'd1;
                end
            end
            if (r_state == S_HIT_RESP) begin
                r_buf_valid <= 1'b0;
                if (r_hit_cnt != 32'hFFFF_FFFF) begin
                    r_hit_cnt <= r_hit_cnt + 32'd1;
                end
            end
            if (r_state == S_PREFETCH && mem_resp) begin
                r_buf_valid <= 1'b1;
                r_buf_tag   <= r_pf_tag;
                r_buf_data  <= mem_rdata;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_i_prefetch_buffer.sv
// ============================================================================
// Module   : tb_i_prefetch_buffer
// Purpose  : Scenario-based self-checking bench for i_prefetch_buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i_prefetch_buffer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         icache_read = 1'b0;
    logic [31:0]  icache_address = '0;
    logic         icache_resp;
    logic [255:0] icache_rdata;
    logic         mem_read;
    logic [31:0]  mem_address;
    logic         mem_resp = 1'b0;
    logic [255:0] mem_rdata = '0;
    logic [31:0]  pf_hit_count;
    logic [31:0]  pf_issue_count;

    logic         np_icache_read = 1'b0;
    logic [31:0]  np_icache_address = '0;
    logic         np_icache_resp;
    logic [255:0] np_icache_rdata;
    logic         np_mem_read;
    logic [31:0]  np_mem_address;
    logic         np_mem_resp = 1'b0;
    logic [255:0] np_mem_rdata = '0;
    logic [31:0]  np_pf_hit_count;
    logic [31:0]  np_pf_issue_count;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int last_resp_cyc = 0;
    logic [255:0] exp_q[$];
    logic [31:0]  mem_log[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    i_prefetch_buffer #(.PREFETCH_EN(1), .LINE_BITS(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .icache_read(icache_read), .icache_address(icache_address),
        .icache_resp(icache_resp), .icache_rdata(icache_rdata),
        .mem_read(mem_read), .mem_address(mem_address),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata),
        .pf_hit_count(pf_hit_count), .pf_issue_count(pf_issue_count)
    );

    i_prefetch_buffer #(.PREFETCH_EN(0), .LINE_BITS(5)) dut_np (
        .clk(clk), .rst_n(rst_n),
        .icache_read(np_icache_read), .icache_address(np_icache_address),
        .icache_resp(np_icache_resp), .icache_rdata(np_icache_rdata),
        .mem_read(np_mem_read), .mem_address(np_mem_address),
        .mem_resp(np_mem_resp), .mem_rdata(np_mem_rdata),
        .pf_hit_count(np_pf_hit_count), .pf_issue_count(np_pf_issue_count)
    );

    function automatic logic [255:0] pattern(input logic [31:0] a);
        logic [255:0] d;
        for (int k = 0; k < 8; k++) begin
            d[k*32 +: 32] = (a ^ 32'h5A00_0000) + 32'(k) * 32'h0101_0101;
        end
        return d;
    endfunction

    // Memory with fixed 3-cycle latency whose line content is a function of its address
    initial begin : mem_model
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk); #1;
            mem_resp = 1'b0;
            if (!rst_n || !mem_read) begin
                cnt = 0;
            end else begin
                if (cnt == 0) mem_log.push_back(mem_address);
                cnt++;
                if (cnt == 3) begin
                    mem_resp      = 1'b1;
                    mem_rdata     = pattern(mem_address);
                    last_resp_cyc = cyc;
                    cnt           = 0;
                end
            end
        end
    end

    task automatic issue_read(input logic [31:0] addr, output logic [255:0] data,
                              output int lat, output int resp_cyc,
                              output logic mr_at_resp, output bit got);
        @(posedge clk); #1;
        icache_read    = 1'b1;
        icache_address = addr;
        got = 1'b0; lat = 0; data = '0; resp_cyc = 0; mr_at_resp = 1'b0;
        for (int i = 1; i <= 60 && !got; i++) begin
            @(negedge clk);
            if (icache_resp) begin
                got = 1'b1; lat = i; data = icache_rdata;
                resp_cyc = cyc; mr_at_resp = mem_read;
            end
        end
        @(posedge clk); #1;
        icache_read = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (!mem_read && !icache_resp) ok = 1'b1;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        icache_read = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({icache_resp, mem_read} !== 2'b00) $display("FAIL reset_ctrl: got=%b exp=00", {icache_resp, mem_read});
        else n_pass++;
        n_checks++;
        if (icache_rdata !== '0) $display("FAIL reset_rdata: got=%h exp=0", icache_rdata);
        else n_pass++;
        n_checks++;
        if (mem_address !== 32'h0) $display("FAIL reset_maddr: got=%h exp=0", mem_address);
        else n_pass++;
        n_checks++;
        if ({pf_hit_count, pf_issue_count} !== 64'd0) $display("FAIL reset_counts: got=%h exp=0", {pf_hit_count, pf_issue_count});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_cold_miss();
        logic [255:0] d, e;
        int lat, rc;
        logic mr;
        bit got, ok;
        mem_log.delete();
        exp_q.push_back(pattern(32'h0000_1000));
        issue_read(32'h0000_1004, d, lat, rc, mr, got);
        e = exp_q.pop_front();
        n_checks++;
        if (!got || d !== e) $display("FAIL cold_data: got=%0b/%h exp=%h", got, d, e);
        else n_pass++;
        n_checks++;
        if (lat != 4) $display("FAIL cold_latency: got=%0d exp=4", lat);
        else n_pass++;
        n_checks++;
        if (mem_log.size() < 1 || mem_log[0] !== 32'h0000_1000) $display("FAIL cold_maddr: got=%h exp=00001000", mem_log.size() > 0 ? mem_log[0] : 32'hX);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (icache_resp !== 1'b0) $display("FAIL cold_single_resp: got=%b exp=0", icache_resp);
        else n_pass++;
        n_checks++;
        if (mem_read !== 1'b1 || mem_address !== 32'h0000_1020) $display("FAIL cold_prefetch: got=%b/%h exp=1/00001020", mem_read, mem_address);
        else n_pass++;
        n_checks++;
        if (pf_issue_count !== 32'd1) $display("FAIL cold_issue_cnt: got=%0d exp=1", pf_issue_count);
        else n_pass++;
        wait_idle(ok);
        n_checks++;
        if (!ok || mem_log.size() != 2) $display("FAIL cold_pf_done: got=%0b/%0d exp=1/2", ok, mem_log.size());
        else n_pass++;
    endtask

    task automatic test_sequential_hit();
        logic [255:0] d, e;
        int lat, rc;
        logic mr;
        bit got, ok;
        mem_log.delete();
        exp_q.push_back(pattern(32'h0000_1020));
        issue_read(32'h0000_1030, d, lat, rc, mr, got);
        e = exp_q.pop_front();
        n_checks++;
        if (!got || d !== e) $display("FAIL hit_data: got=%0b/%h exp=%h", got, d, e);
        else n_pass++;
        n_checks++;
        if (lat != 2 || mr !== 1'b0) $display("FAIL hit_timing: got=lat%0d/mr%b exp=lat2/mr0", lat, mr);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (mem_read !== 1'b1 || mem_address !== 32'h0000_1040) $display("FAIL hit_prefetch: got=%b/%h exp=1/00001040", mem_read, mem_address);
        else n_pass++;
        n_checks++;
        if (pf_hit_count !== 32'd1 || pf_issue_count !== 32'd2) $display("FAIL hit_counts: got=%0d/%0d exp=1/2", pf_hit_count, pf_issue_count);
        else n_pass++;
        wait_idle(ok);
        n_checks++;
        if (!ok || mem_log.size() != 1 || mem_log[0] !== 32'h0000_1040) $display("FAIL hit_memtraffic: got=%0b/%0d exp=1/1", ok, mem_log.size());
        else n_pass++;
    endtask

    task automatic test_request_during_prefetch();
        logic [255:0] d, e;
        int lat, rc;
        logic mr;
        bit got, ok;
        apply_reset();
        mem_log.delete();
        issue_read(32'h0000_1004, d, lat, rc, mr, got);
        exp_q.push_back(pattern(32'h0000_1020));
        issue_read(32'h0000_1020, d, lat, rc, mr, got);
        e = exp_q.pop_front();
        n_checks++;
        if (!got || d !== e) $display("FAIL dpf_data: got=%0b/%h exp=%h", got, d, e);
        else n_pass++;
        n_checks++;
        if (rc - last_resp_cyc != 2) $display("FAIL dpf_latency: got=%0d exp=2", rc - last_resp_cyc);
        else n_pass++;
        wait_idle(ok);
        n_checks++;
        if (!ok || mem_log.size() != 3 || mem_log[1] !== 32'h0000_1020 || mem_log[2] !== 32'h0000_1040)
            $display("FAIL dpf_memtraffic: got=%0b/%0d exp=1/3 (1000,1020,1040)", ok, mem_log.size());
        else n_pass++;
        n_checks++;
        if (pf_hit_count !== 32'd1) $display("FAIL dpf_hit_cnt: got=%0d exp=1", pf_hit_count);
        else n_pass++;
    endtask

    task automatic test_non_matching();
        logic [255:0] d, e;
        int lat, rc;
        logic mr;
        bit got, ok;
        apply_reset();
        issue_read(32'h0000_1004, d, lat, rc, mr, got);
        wait_idle(ok);
        mem_log.delete();
        exp_q.push_back(pattern(32'h0000_8000));
        issue_read(32'h0000_8000, d, lat, rc, mr, got);
        e = exp_q.pop_front();
        n_checks++;
        if (!got || d !== e || lat != 4) $display("FAIL nm_demand: got=%0b/%0d/%h exp=1/4/%h", got, lat, d, e);
        else n_pass++;
        wait_idle(ok);
        n_checks++;
        if (!ok || mem_log.size() != 2 || mem_log[0] !== 32'h0000_8000 || mem_log[1] !== 32'h0000_8020)
            $display("FAIL nm_memtraffic: got=%0b/%0d exp=1/2 (8000,8020)", ok, mem_log.size());
        else n_pass++;
        n_checks++;
        if (pf_hit_count !== 32'd0) $display("FAIL nm_hit_cnt: got=%0d exp=0", pf_hit_count);
        else n_pass++;
        exp_q.push_back(pattern(32'h0000_8020));
        issue_read(32'h0000_8024, d, lat, rc, mr, got);
        e = exp_q.pop_front();
        n_checks++;
        if (!got || d !== e || lat != 2) $display("FAIL nm_replaced: got=%0b/%0d/%h exp=1/2/%h", got, lat, d, e);
        else n_pass++;
        wait_idle(ok);
    endtask

    task automatic test_wrap();
        logic [255:0] d, e;
        int lat, rc;
        logic mr;
        bit got, ok;
        mem_log.delete();
        exp_q.push_back(pattern(32'hFFFF_FFE0));
        issue_read(32'hFFFF_FFE0, d, lat, rc, mr, got);
        e = exp_q.pop_front();
        n_checks++;
        if (!got || d !== e) $display("FAIL wrap_data: got=%0b/%h exp=%h", got, d, e);
        else n_pass++;
        wait_idle(ok);
        n_checks++;
        if (!ok || mem_log.size() != 2 || mem_log[1] !== 32'h0000_0000)
            $display("FAIL wrap_pf_addr: got=%0b/%0d/%h exp=1/2/00000000", ok, mem_log.size(), mem_log.size() > 1 ? mem_log[1] : 32'hX);
        else n_pass++;
        exp_q.push_back(pattern(32'h0000_0000));
        issue_read(32'h0000_0010, d, lat, rc, mr, got);
        e = exp_q.pop_front();
        n_checks++;
        if (!got || d !== e || lat != 2) $display("FAIL wrap_hit: got=%0b/%0d/%h exp=1/2/%h", got, lat, d, e);
        else n_pass++;
        wait_idle(ok);
    endtask

    task automatic test_disable();
        bit seen, stray;
        logic [255:0] e;
        e = pattern(32'hFFFF_FFE0);
        @(posedge clk); #1;
        np_icache_read    = 1'b1;
        np_icache_address = 32'hFFFF_FFE0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (np_mem_read) seen = 1'b1;
        end
        n_checks++;
        if (!seen || np_mem_address !== 32'hFFFF_FFE0) $display("FAIL dis_demand: got=%0b/%h exp=1/ffffffe0", seen, np_mem_address);
        else n_pass++;
        @(posedge clk); #1;
        np_mem_resp  = 1'b1;
        np_mem_rdata = e;
        @(negedge clk);
        n_checks++;
        if (np_icache_resp !== 1'b1 || np_icache_rdata !== e) $display("FAIL dis_resp: got=%b/%h exp=1/%h", np_icache_resp, np_icache_rdata, e);
        else n_pass++;
        @(posedge clk); #1;
        np_mem_resp    = 1'b0;
        np_mem_rdata   = '0;
        np_icache_read = 1'b0;
        stray = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (np_mem_read) stray = 1'b1;
        end
        n_checks++;
        if (stray || np_pf_issue_count !== 32'd0) $display("FAIL dis_no_prefetch: got=%0b/%0d exp=0/0", stray, np_pf_issue_count);
        else n_pass++;
        @(posedge clk); #1;
        np_icache_read    = 1'b1;
        np_icache_address = 32'hFFFF_FFE4;
        repeat (2) @(negedge clk);
        n_checks++;
        if (np_mem_read !== 1'b1 || np_icache_resp !== 1'b0) $display("FAIL dis_refetch: got=%b/%b exp=1/0", np_mem_read, np_icache_resp);
        else n_pass++;
        @(posedge clk); #1;
        np_mem_resp  = 1'b1;
        np_mem_rdata = e;
        @(negedge clk);
        @(posedge clk); #1;
        np_mem_resp    = 1'b0;
        np_icache_read = 1'b0;
        @(negedge clk);
        n_checks++;
        if (np_pf_hit_count !== 32'd0 || np_mem_read !== 1'b0) $display("FAIL dis_final: got=%0d/%b exp=0/0", np_pf_hit_count, np_mem_read);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        logic [255:0] d, e;
        int lat, rc;
        logic mr;
        bit got, ok;
        apply_reset();
        issue_read(32'h0000_1004, d, lat, rc, mr, got);
        wait_idle(ok);
        @(posedge clk); #1;
        icache_read    = 1'b1;
        icache_address = 32'h0000_2000;
        repeat (2) @(negedge clk);
        n_checks++;
        if (mem_read !== 1'b1) $display("FAIL ar_in_demand: got=%b exp=1", mem_read);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (mem_read !== 1'b0 || icache_resp !== 1'b0 || mem_address !== 32'h0) $display("FAIL ar_immediate: got=%b/%b/%h exp=0/0/0", mem_read, icache_resp, mem_address);
        else n_pass++;
        n_checks++;
        if (pf_issue_count !== 32'd0) $display("FAIL ar_counts: got=%0d exp=0", pf_issue_count);
        else n_pass++;
        icache_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mem_log.delete();
        exp_q.push_back(pattern(32'h0000_1020));
        issue_read(32'h0000_1020, d, lat, rc, mr, got);
        e = exp_q.pop_front();
        n_checks++;
        if (!got || d !== e || lat != 4) $display("FAIL ar_miss_after: got=%0b/%0d/%h exp=1/4/%h", got, lat, d, e);
        else n_pass++;
        n_checks++;
        if (mem_log.size() < 1 || mem_log[0] !== 32'h0000_1020) $display("FAIL ar_miss_addr: got=%0d entries exp=1020 first", mem_log.size());
        else n_pass++;
        wait_idle(ok);
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_sequential_hit();
        test_request_during_prefetch();
        test_non_matching();
        test_wrap();
        test_disable();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
